// File: rtl/adder8_pkg.sv
// adder8_pkg: shared width, word and result types for the registered adder.
// Optional feature macro used by this slice: ADDER8_OVERFLOW_EN (adds ovf output).
package adder8_pkg;

    localparam int ADDER_WIDTH = 8;

    typedef logic [ADDER_WIDTH-1:0] word_t;

    typedef struct packed {
        logic  cout;
        word_t sum;
    } add_result_t;

endpackage : adder8_pkg

// File: rtl/adder8_reg_fa_cell.sv
// fa_cell: 1-bit full adder, purely combinational link of the ripple chain.
module fa_cell (
    input  logic cin,
    input  logic a,
    input  logic b,
    output logic cout,
    output logic sum
);

    logic w_prop;

    // Propagate/generate form of the full adder
    always_comb begin
        w_prop = a ^ b;
        sum    = w_prop ^ cin;
        cout   = (a & b) | (cin & w_prop);
    end

endmodule : fa_cell

// File: rtl/adder8_reg.sv
// adder8_reg: ripple-carry adder (chain of fa_cell) with a registered result
// and valid flag. Build macro ADDER8_OVERFLOW_EN adds a registered signed
// overflow flag (ovf); the default build omits it entirely.
module adder8_reg
    import adder8_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef ADDER8_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             out_valid
);

    // w_carry[i] is the carry into cell i; w_carry[WIDTH] is the final carry out
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_valid;

    assign w_carry[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chain
            fa_cell u_fa (
                .cin  (w_carry[gi]),
                .a    (a[gi]),
                .b    (b[gi]),
                .cout (w_carry[gi+1]),
                .sum  (w_sum[gi])
            );
        end
    endgenerate

    // Result register: load only on accepted input so idle-cycle inputs
    // (including X) never reach the outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (in_valid) begin
            r_sum  <= w_sum;
            r_cout <= w_carry[WIDTH];
        end
    end

    // Valid flag follows in_valid with one cycle of latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
        end
    end

`ifdef ADDER8_OVERFLOW_EN
    logic r_ovf;

    // Two's-complement overflow: carry into MSB differs from carry out of MSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (in_valid) begin
            r_ovf <= w_carry[WIDTH] ^ w_carry[WIDTH-1];
        end
    end

    assign ovf = r_ovf;
`endif

    assign sum       = r_sum;
    assign cout      = r_cout;
    assign out_valid = r_valid;

endmodule : adder8_reg

// File: tb/tb_adder8_reg.sv
// tb_adder8_reg: directed self-checking bench for adder8_reg.
// Honours ADDER8_OVERFLOW_EN to exercise the ovf output when it is built in.
module tb_adder8_reg;
    import adder8_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        cin;
    word_t       a;
    word_t       b;
    word_t       sum;
    logic        cout;
    logic        out_valid;
`ifdef ADDER8_OVERFLOW_EN
    logic        ovf;
`endif

    int checks   = 0;
    int failures = 0;

    adder8_reg #(.WIDTH(ADDER_WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .cin       (cin),
        .a         (a),
        .b         (b),
        .sum       (sum),
        .cout      (cout),
`ifdef ADDER8_OVERFLOW_EN
        .ovf       (ovf),
`endif
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one vector at a negedge and return at the following negedge,
    // i.e. just after the capturing rising edge
    task automatic drive(input logic v, input logic c, input word_t xa, input word_t xb);
        @(negedge clk);
        in_valid = v;
        cin      = c;
        a        = xa;
        b        = xb;
        @(negedge clk);
    endtask

    task automatic test_reset();
        add_result_t got;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        cin      = 1'b1;
        a        = word_t'($urandom);
        b        = word_t'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        got = {cout, sum};
        checks++;
        if (got !== 9'h000 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: got {cout,sum}=%h out_valid=%b, want 000 0", got, out_valid);
        end
        // release reset mid-cycle; nothing should load before the next edge
        @(posedge clk);
        #2 rst_n = 1'b1;
        a   = 8'h10;
        b   = 8'h20;
        cin = 1'b0;
        #1;
        got = {cout, sum};
        checks++;
        if (got !== 9'h000 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got {cout,sum}=%h out_valid=%b, want 000 0", got, out_valid);
        end
        @(posedge clk);
        #1;
        got = {cout, sum};
        checks++;
        if (got !== 9'h030 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL first_capture: got {cout,sum}=%h out_valid=%b, want 030 1", got, out_valid);
        end
    endtask

    task automatic test_reset_midop();
        drive(1'b1, 1'b0, 8'h55, 8'h22);
        checks++;
        if ({cout, sum} !== 9'h077 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL midop_load: got {cout,sum}=%h out_valid=%b, want 077 1", {cout, sum}, out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({cout, sum} !== 9'h000 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midop_async_reset: got {cout,sum}=%h out_valid=%b, want 000 0", {cout, sum}, out_valid);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_cell();
        // bit 0 alone: sum[0] is the cell sum, sum[1] receives the cell carry
        drive(1'b1, 1'b0, 8'h01, 8'h00);
        checks++;
        if (sum[0] !== 1'b1 || sum[1] !== 1'b0 || cout !== 1'b0) begin
            failures++;
            $display("FAIL cell_010: got s=%b c=%b, want s=1 c=0", sum[0], sum[1]);
        end
        drive(1'b1, 1'b0, 8'h01, 8'h01);
        checks++;
        if (sum[0] !== 1'b0 || sum[1] !== 1'b1 || cout !== 1'b0) begin
            failures++;
            $display("FAIL cell_011: got s=%b c=%b, want s=0 c=1", sum[0], sum[1]);
        end
        drive(1'b1, 1'b1, 8'h01, 8'h01);
        checks++;
        if (sum[0] !== 1'b1 || sum[1] !== 1'b1 || cout !== 1'b0) begin
            failures++;
            $display("FAIL cell_111: got s=%b c=%b, want s=1 c=1", sum[0], sum[1]);
        end
    endtask

    task automatic test_directed();
        word_t va [3] = '{8'hFF, 8'h19, 8'h99};
        word_t vb [3] = '{8'h00, 8'h95, 8'h15};
        logic [8:0] exp [3] = '{9'h0FF, 9'h0AE, 9'h0AE};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, va[i], vb[i]);
            checks++;
            if ({cout, sum} !== exp[i] || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL directed_%0d: got {cout,sum}=%h out_valid=%b, want %h 1",
                         i, {cout, sum}, out_valid, exp[i]);
            end
        end
    endtask

    task automatic test_wrap();
        drive(1'b1, 1'b1, 8'hFF, 8'h01);
        checks++;
        if ({cout, sum} !== 9'h101) begin
            failures++;
            $display("FAIL wrap_ff_01_1: got {cout,sum}=%h, want 101", {cout, sum});
        end
        drive(1'b1, 1'b1, 8'hFF, 8'hFF);
        checks++;
        if ({cout, sum} !== 9'h1FF) begin
            failures++;
            $display("FAIL wrap_max: got {cout,sum}=%h, want 1ff", {cout, sum});
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        in_valid = 1'b1; cin = 1'b0; a = 8'h01; b = 8'h01;
        @(negedge clk);
        checks++;
        if ({cout, sum} !== 9'h002 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first: got {cout,sum}=%h out_valid=%b, want 002 1", {cout, sum}, out_valid);
        end
        a = 8'h02; b = 8'h02;
        @(negedge clk);
        checks++;
        if ({cout, sum} !== 9'h004 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second: got {cout,sum}=%h out_valid=%b, want 004 1", {cout, sum}, out_valid);
        end
        // idle cycle with new operand: result must hold, valid must drop
        in_valid = 1'b0; a = 8'hAA; b = 8'h33; cin = 1'b1;
        @(negedge clk);
        checks++;
        if ({cout, sum} !== 9'h004 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_idle: got {cout,sum}=%h out_valid=%b, want 004 0", {cout, sum}, out_valid);
        end
        a = 'x; b = 'x; cin = 1'bx;
        repeat (2) @(negedge clk);
        checks++;
        if ({cout, sum} !== 9'h004 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL hold_x_inputs: got {cout,sum}=%h out_valid=%b, want 004 0", {cout, sum}, out_valid);
        end
    endtask

`ifdef ADDER8_OVERFLOW_EN
    task automatic test_ovf();
        drive(1'b1, 1'b0, 8'h7F, 8'h01);
        checks++;
        if ({cout, sum} !== 9'h080 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_7f_01: got {cout,sum}=%h ovf=%b, want 080 1", {cout, sum}, ovf);
        end
        drive(1'b1, 1'b0, 8'h80, 8'hFF);
        checks++;
        if ({cout, sum} !== 9'h17F || ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_80_ff: got {cout,sum}=%h ovf=%b, want 17f 1", {cout, sum}, ovf);
        end
        drive(1'b0, 1'b0, 8'hFF, 8'h01);
        checks++;
        if (ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_hold: got ovf=%b, want 1", ovf);
        end
        drive(1'b1, 1'b0, 8'hFF, 8'h01);
        checks++;
        if ({cout, sum} !== 9'h100 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_ff_01: got {cout,sum}=%h ovf=%b, want 100 0", {cout, sum}, ovf);
        end
    endtask
`endif

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        cin      = 1'b0;
        a        = '0;
        b        = '0;
        test_reset();
        test_reset_midop();
        test_cell();
        test_directed();
        test_wrap();
        test_back_to_back();
`ifdef ADDER8_OVERFLOW_EN
        test_ovf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_adder8_reg
